// File: rtl/stack_access_unit.sv
// Per-lane eBPF stack LDX/STX unit: byte-addressed requests become 64-bit word reads, writes and RMWs; define STACK_BOUNDS_CHECK_EN for alignment/range faults.
// Latency from accept: load 3, dword store 2, sub-dword store 4, fault 1 cycle.
// Backpressure: req_ready only in IDLE, one request in flight; responses are single-cycle pulses and cannot be stalled.
module stack_access_unit #(
    parameter int unsigned max_entries = 64,
    parameter logic [63:0] stack_base  = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [63:0] stk_read_add,
    input  logic [63:0] stk_read_data,
    output logic [63:0] stk_wrt_add,
    output logic        stk_wrt_en,
    output logic [63:0] stk_wrt_data
);

    localparam int unsigned IW = $clog2(max_entries);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [63:0]   off;
    logic [IW-1:0] req_idx;
    logic [2:0]    req_lane;
    logic          req_fault;
    logic          accept;

    logic [IW-1:0] idx_q;
    logic [2:0]    lane_q;
    logic [1:0]    size_q;
    logic          store_q;
    logic [63:0]   wdata_q;
    logic          wrt_en_q;

    logic [5:0]    shamt;
    logic [63:0]   mask_q;
    logic [63:0]   load_val;
    logic [63:0]   merge_val;

    logic          ready_d;
    logic [63:0]   rd_add_d;
    logic          wr_en_d;
    logic [63:0]   wr_add_d;
    logic [63:0]   wr_data_d;
    logic          resp_vld_d;
    logic [63:0]   resp_data_d;
    logic          resp_err_d;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    assign off      = req_addr - stack_base;
    assign req_idx  = off[IW+2:3];
    assign req_lane = off[2:0];
    assign accept   = req_valid && req_ready;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam logic [63:0] WIN_BYTES = 64'(max_entries) << 3;

    logic misaligned;
    logic out_of_range;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0] != 1'b0;
            2'd2:    misaligned = off[1:0] != 2'b00;
            default: misaligned = off[2:0] != 3'b000;
        endcase
    end

    assign out_of_range = off >= WIN_BYTES;
    assign req_fault    = misaligned || out_of_range;
`else
    // Without checking, the index wraps modulo max_entries; upper offset bits are don't-care.
    logic unused_off_hi;
    assign unused_off_hi = ^off[63:IW+3];
    assign req_fault     = 1'b0;
`endif

    // Lane shift past bit 63 simply drops bytes, which is the intended misaligned behaviour.
    assign shamt     = {lane_q, 3'b000};
    assign mask_q    = size_mask(size_q);
    assign load_val  = (stk_read_data >> shamt) & mask_q;
    assign merge_val = (stk_read_data & ~(mask_q << shamt)) | ((wdata_q & mask_q) << shamt);

    always_comb begin
        state_nxt   = state;
        ready_d     = 1'b0;
        rd_add_d    = '0;
        wr_en_d     = 1'b0;
        wr_add_d    = '0;
        wr_data_d   = '0;
        resp_vld_d  = 1'b0;
        resp_data_d = '0;
        resp_err_d  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_nxt = RESP;
                    end else if (req_store && (req_size == 2'd3)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = store_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Output registers are loaded with the values belonging to the next state.
        ready_d = (state_nxt == IDLE);

        if (state_nxt == RD) begin
            rd_add_d = 64'(req_idx);
        end

        if (state_nxt == WR) begin
            wr_en_d = 1'b1;
            if (state == IDLE) begin
                wr_add_d  = 64'(req_idx);
                wr_data_d = req_wdata;
            end else begin
                wr_add_d  = 64'(idx_q);
                wr_data_d = merge_val;
            end
        end

        if (state_nxt == RESP) begin
            resp_vld_d = 1'b1;
            resp_err_d = (state == IDLE);
            if ((state == WAIT) && !store_q) begin
                resp_data_d = load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            idx_q        <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            store_q      <= 1'b0;
            wdata_q      <= '0;
            stk_read_add <= '0;
            wrt_en_q     <= 1'b0;
            stk_wrt_add  <= '0;
            stk_wrt_data <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            req_ready    <= ready_d;
            stk_read_add <= rd_add_d;
            wrt_en_q     <= wr_en_d;
            stk_wrt_add  <= wr_add_d;
            stk_wrt_data <= wr_data_d;
            resp_valid   <= resp_vld_d;
            resp_data    <= resp_data_d;
            resp_err     <= resp_err_d;
            if (accept) begin
                idx_q   <= req_idx;
                lane_q  <= req_lane;
                size_q  <= req_size;
                store_q <= req_store;
                wdata_q <= req_wdata;
            end
        end
    end

    // Reset asserted during WR must kill the write in that same cycle.
    assign stk_wrt_en = wrt_en_q && reset;

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Per-lane load/store front end for the Sephirot eBPF stack memory; one instance per VLIW lane.
- Takes byte-addressed LDX/STX requests (frame-pointer-relative addresses already added by the lane) and converts them to 64-bit word accesses.
- Drives one read/write port pair of the 4R/4W stack RAM.
- Performs zero-extended sub-dword loads, and read-modify-write for sub-dword stores.

Parameters:
- max_entries, 64, number of 64-bit stack words (64 words = 512-byte eBPF stack); power of two.
- stack_base, 64'h0, byte address of stack word 0; the byte window is [stack_base, stack_base + 8*max_entries).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned (LSBs)
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  64  load result, zero-extended; 0 for stores
- resp_err  output  1  access fault, qualified by resp_valid
- stk_read_add  output  64  word index to stack read port
- stk_read_data  input  64  stack read data; valid the cycle after stk_read_add is presented
- stk_wrt_add  output  64  word index to stack write port
- stk_wrt_en  output  1  stack write enable
- stk_wrt_data  output  64  stack write data

Behaviour:
- Address decode: off = req_addr - stack_base. Word index = off[log2(max_entries)+2:3]. Byte lane = off[2:0].
- Aligned means off[req_size-1:0] == 0; byte accesses are always aligned.
- Out of range means off >= 8*max_entries, with unsigned compare.
- FSM states: IDLE, RD, WAIT, WR, RESP. Each state lasts exactly one cycle except IDLE.
- A request is accepted when req_valid && req_ready in IDLE. On acceptance, addr/size/data/store are registered.
- Transitions from IDLE on accept:
  - fault -> RESP
  - dword store -> WR
  - any other request -> RD
- RD: stk_read_add = word index.
- WAIT: stk_read_data is captured into the buffer.
  - Load: buffer = (data >> 8*lane) masked to the size, zero-extended. Next state RESP.
  - Sub-dword store: the size bytes at the lane are replaced with req_wdata LSBs; other bytes keep the read value. Next state WR.
- WR: stk_wrt_en = 1 for exactly one cycle; stk_wrt_add = index; stk_wrt_data = buffer, or req_wdata for a dword store. Next state RESP.
- RESP: resp_valid = 1, resp_data = buffer (0 for stores), resp_err set if faulted. Next state IDLE.
- Latency from the accept cycle T to resp_valid:
  - load: T+3
  - dword store: T+2
  - sub-dword store: T+4
  - fault: T+1
- Throughput: the next accept can occur the cycle after RESP.
- Faulted requests issue no stack read and no stack write.
- stk_read_add and stk_wrt_add upper bits are zero. All stack-facing outputs and all response outputs are registered.
- Reset (reset == 0 at a clk edge):
  - state IDLE; all outputs 0; req_ready = 0 during reset.
  - req_ready = 1 from the first cycle after reset is released.
- Reset mid-operation: the in-flight request is aborted with no write and no response. A reset asserted in the WR cycle suppresses stk_wrt_en in that cycle.
- Cross-lane RMW hazards on the same word (another lane writing between this lane's RD and WR) are excluded by the compiler schedule and are not detected here.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- Defined: misaligned and out-of-range requests fault exactly as described above.
- Undefined:
  - no fault detection; resp_err is tied 0.
  - word index = off modulo max_entries, so out-of-range addresses wrap inside the stack.
  - misaligned accesses use the lane bits as given; bytes beyond bit 63 are dropped on both load and store.

Test Plan:
- Dword store 64'h1122334455667788 at stack_base+0x1F8, then dword load at the same address -> stk_wrt_en at T+1, index 63; load resp_data 64'h1122334455667788 at T+3, resp_err 0.
- Byte store 8'hAA at stack_base+0x1FB over that word -> read at T+1, write at T+3 with data 64'h11223344AA667788, resp at T+4.
- Half load from stack_base+0x1FC -> resp_data 64'h0000000000003344 (zero-extended).
- Word load from stack_base+0x02 (misaligned) and dword load from stack_base+0x200 (out of range), macro defined -> resp_err 1 at T+1, no stk_wrt_en and no read.
- Same two requests with the macro undefined -> resp_err 0; the 0x200 load reads index 0.
- Reset asserted in the WAIT cycle of a byte store -> no stk_wrt_en and no resp_valid; req_ready returns 1 the cycle after release; the word is unchanged on reload.
